ps2_scan_receiver: RTL
======================

Name: ps2_scan_receiver

Overview:
- Upstream stage of the keyboard path. Receives raw PS/2 device frames on ps2_clk/ps2_data.
- Validates start, parity and stop bits.
- Shifts each good scan byte into a 32-bit history word.
- The Enter-key detector downstream consumes scan_history and busy. It acts only when busy is low and the history has changed.

Parameters:
- FILTER_LEN, 8, consecutive identical synchronized samples needed before a ps2_clk level change is accepted.
- TIMEOUT_CYC, 100000, clk cycles without an accepted ps2_clk falling edge before a partial frame is aborted (2 ms at 50 MHz).

Ports:
- clk  input  1  system clock, 50 MHz nominal.
- rst_n  input  1  asynchronous active-low reset.
- ps2_clk  input  1  raw PS/2 clock from the device, asynchronous.
- ps2_data  input  1  raw PS/2 data from the device, asynchronous.
- scan_history  output  32  last four good bytes; [7:0] is the newest, [31:24] the oldest.
- busy  output  1  high while a frame is in progress.
- byte_valid  output  1  one-cycle pulse when scan_history updates.
- frame_err  output  1  one-cycle pulse when a frame is rejected.

Behaviour:
- Reset (rst_n low, asynchronous): scan_history=0, busy=0, byte_valid=0, frame_err=0, FSM=IDLE, bit counter=0, timeout counter=0. Synchronizers and filter reset to 1 (the bus idle level).
- Synchronization: two-flop synchronizer on each of ps2_clk and ps2_data.
- Clock filter: filtered ps2_clk changes state only after FILTER_LEN consecutive equal synchronized samples.
- Edge detect: fall_tick pulses for one cycle on each 1->0 transition of filtered ps2_clk. Data is sampled from synchronized ps2_data on fall_tick.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall_tick with data=0 (start bit), go to DATA, clear the bit counter, set busy=1. On fall_tick with data=1, stay in IDLE with no error.
  - DATA: each fall_tick shifts the data bit into the shift register, LSB first. After the 8th bit, go to PARITY.
  - PARITY: on fall_tick, latch the parity bit and go to STOP.
  - STOP: on fall_tick, check stop bit == 1 and odd parity (XOR of the 8 data bits and the parity bit == 1).
    - Pass: scan_history <= {scan_history[23:0], byte}; byte_valid=1 for one cycle.
    - Fail: frame_err=1 for one cycle; scan_history unchanged.
    - Either way, return to IDLE.
- busy is registered and deasserts in the same cycle that scan_history updates. Downstream therefore sees busy=0 together with the new history.
- Total latency: from the filtered 11th falling edge to the byte_valid pulse is one clk cycle. The raw edge reaches the filter output 2 + FILTER_LEN cycles after arriving.
- Timeout:
  - The counter clears on every fall_tick and on entry to IDLE, and increments while the FSM is not in IDLE.
  - Reaching TIMEOUT_CYC-1 forces IDLE, busy=0, and frame_err pulses for one cycle. scan_history is unchanged.
- Repeated identical bytes (e.g. typematic repeat) still shift in and still pulse byte_valid.
- Glitches shorter than FILTER_LEN cycles on ps2_clk produce no fall_tick.
- Reset asserted mid-frame discards the partial byte; no pulse is produced after release.
- The block is receive only: it never drives ps2_clk or ps2_data.

Decomposition:
- Shared package ps2_pkg holds:
  - state encoding for IDLE/DATA/PARITY/STOP;
  - FRAME_BITS=11;
  - constants SC_ENTER=8'h5A, SC_BREAK=8'hF0, SC_EXT=8'hE0, so the downstream detector shares the same Enter code.
- One sub-module: ps2_sync_filter, containing the synchronizer, the FILTER_LEN glitch filter and the fall_tick generator. The FSM, checks and history register stay in ps2_scan_receiver.

Test Plan:
- Reset, then send a valid frame for 0x5A (data LSB first 0,1,0,1,1,0,1,0; parity 1; stop 1) at a 12.5 kHz PS/2 clock -> one byte_valid pulse; scan_history=32'h0000005A; busy high from start bit to that cycle; frame_err never asserts.
- Send 0x1C, 0xF0, 0x1C, 0x5A back to back -> four byte_valid pulses; final scan_history=32'h1CF01C5A.
- Send 0x5A with parity 0 -> frame_err pulses once; no byte_valid; scan_history unchanged.
- Send 0x5A with stop bit 0 -> frame_err pulses once; no byte_valid; scan_history unchanged.
- Send start bit plus 4 data bits, then hold ps2_clk high for TIMEOUT_CYC cycles -> busy drops and frame_err pulses. A following valid 0x29 frame then gives scan_history=32'h00000029.
- Inject 3-cycle low glitches on ps2_clk while idle and mid-frame -> no extra bits captured; a following valid frame decodes correctly.
- Assert rst_n low mid-frame, release, then send 0x5A -> busy=0 during reset; only the new frame updates scan_history.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: FSM encoding, frame geometry, well-known
// scan codes and the odd-parity check used on every received byte.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  // start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = FRAME_BITS - 3;

  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Brings the asynchronous PS/2 lines into clk, rejects short ps2_clk glitches
// and emits a one-cycle fall_tick for each accepted falling clock edge.
module ps2_sync_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall_tick,
  output logic data_bit
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] FLT_LAST = CNT_W'(FILTER_LEN - 1);

  logic             clk_meta_r, clk_sync_r;
  logic             data_meta_r, data_sync_r;
  logic             clk_filt_r;
  logic [CNT_W-1:0] flt_cnt_r;
  logic             fall_tick_r;

  // Two-flop synchronizers, reset to the idle-high bus level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= ps2_clk;
      clk_sync_r  <= clk_meta_r;
      data_meta_r <= ps2_data;
      data_sync_r <= data_meta_r;
    end
  end

  // Glitch filter: the filtered clock follows only a level held for FILTER_LEN samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_filt_r  <= 1'b1;
      flt_cnt_r   <= '0;
      fall_tick_r <= 1'b0;
    end else if (clk_sync_r == clk_filt_r) begin
      flt_cnt_r   <= '0;
      fall_tick_r <= 1'b0;
    end else if (flt_cnt_r == FLT_LAST) begin
      clk_filt_r  <= clk_sync_r;
      flt_cnt_r   <= '0;
      fall_tick_r <= ~clk_sync_r;
    end else begin
      flt_cnt_r   <= flt_cnt_r + CNT_W'(1);
      fall_tick_r <= 1'b0;
    end
  end

  assign fall_tick = fall_tick_r;
  assign data_bit  = data_sync_r;

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 frame receiver: checks start/parity/stop, aborts stalled frames and
// shifts every good byte into a four-byte scan history for the key detector.
module ps2_scan_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [31:0] scan_history,
  output logic        busy,
  output logic        byte_valid,
  output logic        frame_err
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  logic             fall_tick_s, data_bit_s;
  ps2_state_e       state_r, state_n;
  logic [2:0]       bit_cnt_r, bit_cnt_n;
  logic [7:0]       shift_r, shift_n;
  logic             parity_r, parity_n;
  logic [TMO_W-1:0] tmo_r, tmo_n;
  logic [31:0]      hist_r, hist_n;
  logic             busy_r, busy_n;
  logic             bv_r, bv_n;
  logic             fe_r, fe_n;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync_filter (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .fall_tick (fall_tick_s),
    .data_bit  (data_bit_s)
  );

  // Frame FSM next-state, frame checks and timeout abort.
  always_comb begin
    state_n   = state_r;
    bit_cnt_n = bit_cnt_r;
    shift_n   = shift_r;
    parity_n  = parity_r;
    hist_n    = hist_r;
    busy_n    = busy_r;
    bv_n      = 1'b0;
    fe_n      = 1'b0;
    if (state_r == ST_IDLE || fall_tick_s) begin
      tmo_n = '0;
    end else begin
      tmo_n = tmo_r + TMO_W'(1);
    end

    // A stalled partial frame is dropped; a real edge on the last count still wins.
    if (state_r != ST_IDLE && !fall_tick_s && tmo_r == TMO_LAST) begin
      state_n = ST_IDLE;
      busy_n  = 1'b0;
      fe_n    = 1'b1;
      tmo_n   = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (fall_tick_s && !data_bit_s) begin
            state_n   = ST_DATA;
            bit_cnt_n = 3'd0;
            busy_n    = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_DATA: begin
          if (fall_tick_s) begin
            shift_n   = {data_bit_s, shift_r[7:1]};
            bit_cnt_n = bit_cnt_r + 3'd1;
            if (bit_cnt_r == LAST_BIT) begin
              state_n = ST_PARITY;
            end else begin
              state_n = ST_DATA;
            end
          end else begin
            state_n = ST_DATA;
          end
        end
        ST_PARITY: begin
          if (fall_tick_s) begin
            parity_n = data_bit_s;
            state_n  = ST_STOP;
          end else begin
            state_n = ST_PARITY;
          end
        end
        ST_STOP: begin
          if (fall_tick_s) begin
            state_n = ST_IDLE;
            busy_n  = 1'b0;
            if (data_bit_s && odd_parity_ok(shift_r, parity_r)) begin
              hist_n = {hist_r[23:0], shift_r};
              bv_n   = 1'b1;
            end else begin
              fe_n = 1'b1;
            end
          end else begin
            state_n = ST_STOP;
          end
        end
        default: begin
          state_n = ST_IDLE;
          busy_n  = 1'b0;
        end
      endcase
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      parity_r  <= 1'b0;
      tmo_r     <= '0;
      hist_r    <= 32'h0000_0000;
      busy_r    <= 1'b0;
      bv_r      <= 1'b0;
      fe_r      <= 1'b0;
    end else begin
      state_r   <= state_n;
      bit_cnt_r <= bit_cnt_n;
      shift_r   <= shift_n;
      parity_r  <= parity_n;
      tmo_r     <= tmo_n;
      hist_r    <= hist_n;
      busy_r    <= busy_n;
      bv_r      <= bv_n;
      fe_r      <= fe_n;
    end
  end

  assign scan_history = hist_r;
  assign busy         = busy_r;
  assign byte_valid   = bv_r;
  assign frame_err    = fe_r;

endmodule
